// File: rtl/tri_adder_core.sv
// Purpose : three independent 32-bit adders (lookahead, carry-skip, 3-operand carry-save) with a CLA/CSK cross-check flag.
// Latency : 1 cycle from in_valid to out_valid; results hold while in_valid is low.
// Backpres: none, a new operand set is accepted every cycle.
module tri_adder_core #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] cla_sum,
    output logic             cla_cout,
    output logic             cla_of,
    output logic [WIDTH-1:0] csk_sum,
    output logic             csk_cout,
    output logic             csk_of,
    output logic [WIDTH-1:0] csv_sum,
    output logic             csv_cout,
    output logic             csv_of,
    output logic             mismatch
);
    localparam int NG = WIDTH / BLK;

    // Carry-lookahead signals
    logic [WIDTH-1:0] cla_g, cla_p, cla_c, cla_sum_d;
    logic [NG-1:0]    grp_g, grp_p;
    logic [NG:0]      grp_c;
    logic             cla_cout_d, cla_of_d;

    // Carry-skip signals
    logic [WIDTH-1:0] csk_p, csk_g, csk_c, csk_sum_d;
    logic [NG-1:0]    csk_rc, csk_bp;
    logic [NG:0]      csk_bc;
    logic             csk_cout_d, csk_of_d;

    // Carry-save signals
    logic [WIDTH-1:0] csv_s, csv_k;
    logic [WIDTH+1:0] csv_x, csv_y, csv_u, csv_rc;
    logic [1:0]       csv_neg, csv_hi;
    logic             csv_cout_d, csv_of_d;

    // Registered state
    logic             out_valid_q;
    logic [WIDTH-1:0] cla_sum_q, csk_sum_q, csv_sum_q;
    logic             cla_cout_q, cla_of_q, csk_cout_q, csk_of_q;
    logic             csv_cout_q, csv_of_q, mismatch_q;
    logic             mismatch_d;

    // CLA: group G/P, second-level lookahead for group carries, in-group carries from the group carry-in
    always_comb begin
        cla_g = a & b;
        cla_p = a ^ b;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        cla_c = '0;
        for (int j = 0; j < NG; j++) begin
            grp_p[j] = &cla_p[j*BLK +: BLK];
            for (int i = 0; i < BLK; i++) begin
                grp_g[j] = cla_g[j*BLK+i] | (cla_p[j*BLK+i] & grp_g[j]);
            end
        end
        grp_c[0] = cin;
        for (int j = 0; j < NG; j++) begin
            grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
        end
        for (int j = 0; j < NG; j++) begin
            cla_c[j*BLK] = grp_c[j];
            for (int i = 0; i < BLK-1; i++) begin
                cla_c[j*BLK+i+1] = cla_g[j*BLK+i] | (cla_p[j*BLK+i] & cla_c[j*BLK+i]);
            end
        end
        cla_sum_d  = cla_p ^ cla_c;
        cla_cout_d = grp_c[NG];
        cla_of_d   = (a[WIDTH-1] == b[WIDTH-1]) && (cla_sum_d[WIDTH-1] != a[WIDTH-1]);
    end

    // CSK: ripple inside each block, block carry bypasses the ripple when the whole block propagates
    always_comb begin
        csk_g  = a & b;
        csk_p  = a ^ b;
        csk_c  = '0;
        csk_rc = '0;
        csk_bp = '0;
        csk_bc = '0;
        csk_bc[0] = cin;
        for (int j = 0; j < NG; j++) begin
            csk_bp[j]    = &csk_p[j*BLK +: BLK];
            csk_c[j*BLK] = csk_bc[j];
            for (int i = 0; i < BLK-1; i++) begin
                csk_c[j*BLK+i+1] = csk_g[j*BLK+i] | (csk_p[j*BLK+i] & csk_c[j*BLK+i]);
            end
            csk_rc[j]   = csk_g[j*BLK+BLK-1] | (csk_p[j*BLK+BLK-1] & csk_c[j*BLK+BLK-1]);
            csk_bc[j+1] = csk_bp[j] ? csk_bc[j] : csk_rc[j];
        end
        csk_sum_d  = csk_p ^ csk_c;
        csk_cout_d = csk_bc[NG];
        csk_of_d   = (a[WIDTH-1] == b[WIDTH-1]) && (csk_sum_d[WIDTH-1] != a[WIDTH-1]);
    end

    // CSV: full-adder row then a WIDTH+2 ripple; signed overflow by removing each negative operand's 2^WIDTH weight
    always_comb begin
        csv_s  = a ^ b ^ c;
        csv_k  = (a & b) | (a & c) | (b & c);
        csv_x  = {2'b00, csv_s};
        csv_y  = {1'b0, csv_k, 1'b0};
        csv_u  = '0;
        csv_rc = '0;
        for (int i = 0; i < WIDTH+2; i++) begin
            csv_u[i] = csv_x[i] ^ csv_y[i] ^ csv_rc[i];
            if (i < WIDTH+1) begin
                csv_rc[i+1] = (csv_x[i] & csv_y[i]) | (csv_rc[i] & (csv_x[i] ^ csv_y[i]));
            end
        end
        csv_neg    = {1'b0, a[WIDTH-1]} + {1'b0, b[WIDTH-1]} + {1'b0, c[WIDTH-1]};
        csv_hi     = csv_u[WIDTH+1:WIDTH] - csv_neg;
        csv_cout_d = csv_u[WIDTH+1] | csv_u[WIDTH];
        // In range only when the top three bits of the signed sum are a pure sign extension
        csv_of_d   = !(((csv_hi == 2'b00) && !csv_u[WIDTH-1]) ||
                       ((csv_hi == 2'b11) &&  csv_u[WIDTH-1]));
        mismatch_d = (cla_sum_d != csk_sum_d) || (cla_cout_d != csk_cout_d);
    end

    // Output registers: capture on valid, hold otherwise, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            cla_sum_q   <= '0;
            cla_cout_q  <= 1'b0;
            cla_of_q    <= 1'b0;
            csk_sum_q   <= '0;
            csk_cout_q  <= 1'b0;
            csk_of_q    <= 1'b0;
            csv_sum_q   <= '0;
            csv_cout_q  <= 1'b0;
            csv_of_q    <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                cla_sum_q  <= cla_sum_d;
                cla_cout_q <= cla_cout_d;
                cla_of_q   <= cla_of_d;
                csk_sum_q  <= csk_sum_d;
                csk_cout_q <= csk_cout_d;
                csk_of_q   <= csk_of_d;
                csv_sum_q  <= csv_u[WIDTH-1:0];
                csv_cout_q <= csv_cout_d;
                csv_of_q   <= csv_of_d;
                mismatch_q <= mismatch_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign cla_sum   = cla_sum_q;
    assign cla_cout  = cla_cout_q;
    assign cla_of    = cla_of_q;
    assign csk_sum   = csk_sum_q;
    assign csk_cout  = csk_cout_q;
    assign csk_of    = csk_of_q;
    assign csv_sum   = csv_sum_q;
    assign csv_cout  = csv_cout_q;
    assign csv_of    = csv_of_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_tri_adder_core.sv
// Purpose : scoreboard bench for tri_adder_core: reset, overflow/wrap corners, skip path, three-operand sums, random stream.
// Latency : expects each result one cycle after its valid input, held while in_valid is low.
// Backpres: none, stimulus may be valid every cycle.
module tb_tri_adder_core;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b, c;
    logic        cin;
    logic        out_valid;
    logic [31:0] cla_sum, csk_sum, csv_sum;
    logic        cla_cout, cla_of, csk_cout, csk_of, csv_cout, csv_of, mismatch;

    typedef struct packed {
        logic [31:0] cla_sum;
        logic        cla_cout;
        logic        cla_of;
        logic [31:0] csk_sum;
        logic        csk_cout;
        logic        csk_of;
        logic [31:0] csv_sum;
        logic        csv_cout;
        logic        csv_of;
        logic        mismatch;
    } res_t;

    res_t exp_q[$];
    res_t last_exp;
    logic prev_vld;
    int   n_checks;
    int   n_errors;

    tri_adder_core #(.WIDTH(32), .BLK(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c        (c),
        .cin      (cin),
        .out_valid(out_valid),
        .cla_sum  (cla_sum),
        .cla_cout (cla_cout),
        .cla_of   (cla_of),
        .csk_sum  (csk_sum),
        .csk_cout (csk_cout),
        .csk_of   (csk_of),
        .csv_sum  (csv_sum),
        .csv_cout (csv_cout),
        .csv_of   (csv_of),
        .mismatch (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the definitions, in plain wide integers
    function automatic res_t model(input logic [31:0] ia, ib, ic, input logic icin);
        res_t        r;
        logic [32:0] s2;
        logic [33:0] u;
        longint      ss;
        s2 = {1'b0, ia} + {1'b0, ib} + {32'b0, icin};
        r.cla_sum  = s2[31:0];
        r.cla_cout = s2[32];
        r.cla_of   = (ia[31] == ib[31]) && (s2[31] != ia[31]);
        r.csk_sum  = r.cla_sum;
        r.csk_cout = r.cla_cout;
        r.csk_of   = r.cla_of;
        u = {2'b00, ia} + {2'b00, ib} + {2'b00, ic};
        r.csv_sum  = u[31:0];
        r.csv_cout = u[33] | u[32];
        ss = longint'($signed(ia)) + longint'($signed(ib)) + longint'($signed(ic));
        r.csv_of   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        r.mismatch = 1'b0;
        return r;
    endfunction

    task automatic compare_outputs();
        res_t e;
        check("out_valid", 64'(out_valid), 64'(prev_vld));
        e = last_exp;
        if (prev_vld) begin
            check("sb_depth", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_exp = e;
            end
        end
        check("cla_sum",  64'(cla_sum),  64'(e.cla_sum));
        check("cla_cout", 64'(cla_cout), 64'(e.cla_cout));
        check("cla_of",   64'(cla_of),   64'(e.cla_of));
        check("csk_sum",  64'(csk_sum),  64'(e.csk_sum));
        check("csk_cout", 64'(csk_cout), 64'(e.csk_cout));
        check("csk_of",   64'(csk_of),   64'(e.csk_of));
        check("csv_sum",  64'(csv_sum),  64'(e.csv_sum));
        check("csv_cout", 64'(csv_cout), 64'(e.csv_cout));
        check("csv_of",   64'(csv_of),   64'(e.csv_of));
        check("mismatch", 64'(mismatch), 64'(e.mismatch));
    endtask

    task automatic cycle(input logic v, input logic [31:0] ia, ib, ic, input logic icin);
        @(negedge clk);
        compare_outputs();
        in_valid = v;
        a        = ia;
        b        = ib;
        c        = ic;
        cin      = icin;
        if (v && rst_n) exp_q.push_back(model(ia, ib, ic, icin));
        prev_vld = v && rst_n;
    endtask

    // Directed vectors: overflow corners, wraps, skip path, three-operand cases
    localparam int ND = 13;
    logic [31:0] da [ND] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000001,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0000FFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40000000, 32'h80000000,
                             32'hAAAAAAAA};
    logic [31:0] db [ND] = '{32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
                             32'hFFFFFFFF, 32'h00000001, 32'h0000FFFF, 32'h00FF0000,
                             32'h00000000, 32'hFFFFFFFF, 32'h40000000, 32'h80000000,
                             32'h55555555};
    logic [31:0] dc [ND] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                             32'h0, 32'hFFFFFFFF, 32'h40000000, 32'h80000000, 32'h0};
    logic        dcin[ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        n_checks = 0;
        n_errors = 0;
        prev_vld = 1'b0;
        last_exp = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; c = '0; cin = 1'b0;

        // Reset held with random valid traffic: outputs must stay zero
        for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
        cycle(1'b0, '0, '0, '0, 1'b0);
        rst_n = 1'b1;

        // Directed vectors back-to-back
        for (int i = 0; i < ND; i++) cycle(1'b1, da[i], db[i], dc[i], dcin[i]);
        // Hold check
        cycle(1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Random stream with in_valid toggling
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb, rc;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ~ra : $urandom;
            rc = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            cycle(1'($urandom_range(0, 1)), ra, rb, rc, 1'($urandom_range(0, 1)));
        end

        // Reset mid-stream: outputs clear immediately, nothing leaks out after release
        cycle(1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h1, 1'b0);
        cycle(1'b1, 32'hDEADBEEF, 32'h01234567, 32'h2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        last_exp = '0;
        prev_vld = 1'b0;
        compare_outputs();
        cycle(1'b1, 32'hFFFFFFFF, 32'h1, 32'h3, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        cycle(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tri_adder_core.md
Name: tri_adder_core

Overview:
- Registered 32-bit adder core containing three independent adder structures on a shared operand bus:
  - carry-lookahead adder (CLA)
  - carry-skip adder (CSK)
  - three-operand carry-save adder (CSV)
- Each structure produces a sum, a carry-out and a signed-overflow flag, captured into output registers one cycle after a valid input.
- Sits in the arithmetic datapath as the selectable/cross-checkable adder resource. A mismatch flag supports on-line self-checking.

Parameters:
- WIDTH, 32, operand and sum width. Must be a multiple of 4.
- BLK, 4, CLA group size and carry-skip block size.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  operand A (two's complement)
- b  input  WIDTH  operand B (two's complement)
- c  input  WIDTH  third operand, used by CSV only
- cin  input  1  carry-in for CLA and CSK (CSV ignores it)
- out_valid  output  1  registered in_valid
- cla_sum  output  WIDTH  CLA result
- cla_cout  output  1  CLA carry-out
- cla_of  output  1  CLA signed overflow
- csk_sum  output  WIDTH  CSK result
- csk_cout  output  1  CSK carry-out
- csk_of  output  1  CSK signed overflow
- csv_sum  output  WIDTH  CSV result
- csv_cout  output  1  CSV unsigned carry-out
- csv_of  output  1  CSV signed overflow
- mismatch  output  1  CLA and CSK results disagree

Behaviour:
- Reset: while rst_n=0, all outputs are 0, asynchronously. The first capture happens on the first rising clk edge after rst_n rises.
- Latency: exactly 1 cycle.
  - On a rising clk edge with in_valid=1, all result registers load from the combinational adders and out_valid goes to 1.
  - With in_valid=0, out_valid goes to 0 and result registers hold their previous values.
- No backpressure. A new operand set is accepted every cycle.
- CLA:
  - {cla_cout, cla_sum} = a + b + cin, modulo 2^(WIDTH+1).
  - Structure: BLK-bit lookahead groups with per-bit generate/propagate. Group G/P feed a second-level lookahead unit for the inter-group carries.
- CSK:
  - Same arithmetic as CLA.
  - Structure: BLK-bit ripple blocks. A block's carry-in bypasses to its carry-out when all of that block's propagate bits are 1.
- Overflow (CLA and CSK): of = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]). It is independent of cout.
- CSV:
  - Stage 1: a bitwise full-adder row on a, b, c produces a partial-sum vector s and a carry vector k shifted left by 1.
  - Stage 2: a WIDTH+2-bit final ripple add.
  - Define U = unsigned 34-bit a+b+c. Then csv_sum = U[31:0] and csv_cout = U[33] | U[32].
  - csv_of = 1 when the signed sum (operands sign-extended to 34 bits) lies outside [-2^31, 2^31-1].
  - With c=0 the CSV outputs equal the CLA outputs computed with cin=0.
- mismatch = registered (cla_sum != csk_sum) || (cla_cout != csk_cout). It is 0 in any correct implementation and is checked by verification.
- Boundaries:
  - all-ones plus 1 wraps to 0 with cout=1, of=0.
  - most-positive plus 1 gives most-negative with of=1, cout=0.
  - most-negative plus -1 gives most-positive with of=1, cout=1.
  - cin=1 with full propagate (a ^ b all ones) must ripple or skip through every block.
  - Reset asserted mid-stream clears outputs immediately. No partial result appears after release.

Test Plan:
- Reset: drive rst_n=0 with random operands and toggling clk -> all outputs 0. Release, then in_valid=1 -> out_valid=1 on the next edge.
- Signed-overflow vectors, c=0, cin=0, all three adders:
  - 7FFFFFFF+00000001 -> 80000000, cout0, of1
  - FFFFFFFF+80000000 -> 7FFFFFFF, cout1, of1
  - 7FFFFFFF+FFFFFFFF -> 7FFFFFFE, cout1, of0
  - 00000001+80000000 -> 80000001, cout0, of0
- General vectors, c=0, cin=0:
  - FFFFFFFF+FFFFFFFF -> FFFFFFFE, cout1, of0
  - FFFFFFFF+00000001 -> 00000000, cout1, of0
  - 0000FFFF+0000FFFF -> 0001FFFE, cout0
  - 0000FFFF+00FF0000 -> 00FFFFFF, cout0
- Carry-in / skip path: a=FFFFFFFF, b=00000000, cin=1 -> CLA and CSK give 00000000, cout1, of0, mismatch0. CSV gives FFFFFFFF, cout0.
- Three operands: a=b=c=FFFFFFFF -> csv_sum FFFFFFFD, csv_cout1, csv_of0. a=b=c=40000000 -> csv_sum C0000000, csv_of1.
- Throughput: back-to-back random vectors with in_valid toggling -> each result appears exactly one cycle later, outputs hold when in_valid=0, mismatch stays 0.
